fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: default widths and the fetch FSM state encoding.
package fetch_pkg;

    localparam int unsigned PC_W    = 5;
    localparam int unsigned INSTR_W = 13;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a synchronous instruction memory and presents
// the returned word as the current instruction with its address and valid flag.
module fetch_ctrl #(
    parameter int unsigned     PC_W     = fetch_pkg::PC_W,
    parameter int unsigned     INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall_i,
    input  logic                         redirect_i,
    input  logic [PC_W-1:0]              redirect_pc_i,
    input  logic                         halt_i,
    input  logic                         resume_i,
    output logic [PC_W-1:0]              imem_addr_o,
    input  logic [INSTR_W-1:0]           imem_data_i,
    output logic [PC_W-1:0]              pc_o,
    output logic [INSTR_W-1:0]           ir_o,
    output logic [PC_W-1:0]              ir_pc_o,
    output logic                         ir_valid_o,
    output logic [1:0]                   state_o,
    output logic [fetch_pkg::CNT_W-1:0]  fetch_cnt_o
);

    localparam int unsigned              CNT_W   = fetch_pkg::CNT_W;
    localparam logic [CNT_W-1:0]         CNT_MAX = '1;

    fetch_pkg::state_e state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   ir_pc_q, ir_pc_d;
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   addr_c;
    logic [CNT_W-1:0]  cnt_q;

    // State and fetch registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= fetch_pkg::ST_BOOT;
            pc_q    <= RESET_PC;
            ir_pc_q <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
        end
    end

    // Next state, next PC and memory address; priority redirect > halt > stall > advance
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
        addr_c  = pc_q;
        unique case (state_q)
            fetch_pkg::ST_BOOT: begin
                addr_c  = RESET_PC;
                pc_d    = RESET_PC + PC_W'(1);
                ir_pc_d = RESET_PC;
                valid_d = 1'b1;
                state_d = fetch_pkg::ST_RUN;
            end
            fetch_pkg::ST_RUN: begin
                if (redirect_i) begin
                    addr_c  = redirect_pc_i;
                    pc_d    = redirect_pc_i + PC_W'(1);
                    ir_pc_d = redirect_pc_i;
                    valid_d = 1'b1;
                end else if (halt_i) begin
                    valid_d = 1'b0;
                    state_d = fetch_pkg::ST_HALT;
                end else if (stall_i) begin
                    // Refetch the held instruction so ir_o stays stable next cycle
                    addr_c = ir_pc_q;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    ir_pc_d = pc_q;
                    valid_d = 1'b1;
                end
            end
            fetch_pkg::ST_HALT: begin
                if (redirect_i) begin
                    addr_c  = redirect_pc_i;
                    pc_d    = redirect_pc_i + PC_W'(1);
                    ir_pc_d = redirect_pc_i;
                    valid_d = 1'b1;
                    state_d = fetch_pkg::ST_RUN;
                end else if (resume_i && !halt_i) begin
                    pc_d    = pc_q + PC_W'(1);
                    ir_pc_d = pc_q;
                    valid_d = 1'b1;
                    state_d = fetch_pkg::ST_RUN;
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = fetch_pkg::ST_BOOT;
            end
        endcase
    end

    // Saturating count of delivered instructions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (valid_q && !stall_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign imem_addr_o = addr_c;
    assign pc_o        = pc_q;
    assign ir_o        = imem_data_i;
    assign ir_pc_o     = ir_pc_q;
    assign ir_valid_o  = valid_q;
    assign state_o     = state_q;
    assign fetch_cnt_o = cnt_q;

endmodule
